// File: rtl/int_multiplier.sv
// -----------------------------------------------------------------------------
// int_multiplier
//
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// Operands are accepted on an InValid/InReady handshake and the 2*WIDTH-bit
// product is returned on an OutValid/OutReady handshake, matching the
// interface of the shift-subtract integer divider it pairs with.
//
// Optional build macro: INT_MULT_EARLY_TERM_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero, so small multipliers finish early. The product is unchanged and
//   the interface is identical in both builds.
// -----------------------------------------------------------------------------
module int_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    // Operand width outside 2..32 is not a supported configuration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("int_multiplier: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q,   state_d;
    logic [PW-1:0]   acc_q,     acc_d;
    logic [PW-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [PW-1:0]   product_q, product_d;

    // Multiplier bits still to be consumed after this RUN edge.
    logic [WIDTH-1:0] mplier_shift;
    // High on the RUN edge that performs the final add.
    logic             last_step;

    assign mplier_shift = mplier_q >> 1;

`ifdef INT_MULT_EARLY_TERM_EN
    // Stop once no set multiplier bits remain; the count still bounds RUN.
    assign last_step = (count_q == LAST_COUNT) || (mplier_shift == '0);
`else
    // Always walk every multiplier bit.
    assign last_step = (count_q == LAST_COUNT);
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                // The accumulator is 2*WIDTH wide, so this add never wraps.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                count_d  = count_q + CW'(1);
                if (last_step) begin
                    // Capture the finished sum so Product stays put after the
                    // accumulator is cleared by the next accept.
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end

            DONE: begin
                // Operands are ignored here; only the retire handshake matters.
                if (OutReady) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: the datapath registers are reset too, not just the state,
            // so Product reads 0 after reset and an aborted operation leaves
            // nothing behind.
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the edge.
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q != IDLE);
    assign Product  = product_q;

endmodule

// File: tb/tb_int_multiplier.sv
// -----------------------------------------------------------------------------
// tb_int_multiplier
//
// Directed table of operand pairs with hand-computed products on a WIDTH=8
// instance, hand-written sequences for backpressure, operands offered during
// DONE and reset mid-operation, then random back-to-back traffic with random
// OutReady stalls on WIDTH=8 and WIDTH=16 instances against a queue of
// expected products.
// -----------------------------------------------------------------------------
module tb_int_multiplier;

`ifdef INT_MULT_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam int NUM_RAND = 30;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_multiplier #(.WIDTH(8)) u_dut8 (
        .Clk      (clk),
        .Rst      (rst),
        .InValid  (in_valid8),
        .InReady  (in_ready8),
        .A        (a8),
        .B        (b8),
        .OutValid (out_valid8),
        .OutReady (out_ready8),
        .Product  (product8),
        .Busy     (busy8)
    );

    int_multiplier #(.WIDTH(16)) u_dut16 (
        .Clk      (clk),
        .Rst      (rst),
        .InValid  (in_valid16),
        .InReady  (in_ready16),
        .A        (a16),
        .B        (b16),
        .OutValid (out_valid16),
        .OutReady (out_ready16),
        .Product  (product16),
        .Busy     (busy16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // RUN edges when early termination is built in: highest set bit + 1, B=0 -> 1.
    function automatic int early_runs(input logic [7:0] b);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = i + 1;
        end
        return r;
    endfunction

    function automatic int exp_runs8(input logic [7:0] b);
        return EARLY_TERM ? early_runs(b) : 8;
    endfunction

    // Wait (bounded) for OutValid on the 8-bit instance, counting edges.
    task automatic wait_out8(input string name, output int edges);
        edges = 0;
        while (!out_valid8 && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check({name, " out_valid rise"}, 32'(out_valid8), 32'(1));
    endtask

    // Apply one operand pair, check latency, product, stall hold and retire.
    task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input int stall, input logic [15:0] exp);
        int edges;
        @(negedge clk);
        a8 = a; b8 = b; in_valid8 = 1'b1; out_ready8 = (stall == 0);
        @(negedge clk);
        in_valid8 = 1'b0;
        check({name, " busy after accept"}, 32'(busy8), 32'(1));
        check({name, " in_ready after accept"}, 32'(in_ready8), 32'(0));
        wait_out8(name, edges);
        check({name, " latency"}, 32'(edges), 32'(exp_runs8(b)));
        check({name, " product"}, 32'(product8), 32'(exp));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check({name, " stall product"}, 32'(product8), 32'(exp));
            check({name, " stall out_valid"}, 32'(out_valid8), 32'(1));
            check({name, " stall in_ready"}, 32'(in_ready8), 32'(0));
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        check({name, " out_valid drop"}, 32'(out_valid8), 32'(0));
        check({name, " in_ready back"}, 32'(in_ready8), 32'(1));
        check({name, " busy clear"}, 32'(busy8), 32'(0));
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    // Random-phase scoreboards and monitors.
    logic [15:0] exp_q8  [$];
    logic [31:0] exp_q16 [$];
    int  got8  = 0;
    int  got16 = 0;
    bit  rand_on    = 1'b0;
    bit  drv8_done  = 1'b0;
    bit  drv16_done = 1'b0;
    logic [15:0] mon_exp8;
    logic [31:0] mon_exp16;

    always @(negedge clk) begin
        if (rand_on && out_valid8 && out_ready8) begin
            if (exp_q8.size() == 0) begin
                check("rand8 spurious result", 32'(1), 32'(0));
            end else begin
                mon_exp8 = exp_q8.pop_front();
                check("rand8 product", 32'(product8), 32'(mon_exp8));
                got8++;
            end
        end
    end

    always @(negedge clk) begin
        if (rand_on && out_valid16 && out_ready16) begin
            if (exp_q16.size() == 0) begin
                check("rand16 spurious result", 32'(1), 32'(0));
            end else begin
                mon_exp16 = exp_q16.pop_front();
                check("rand16 product", product16, mon_exp16);
                got16++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        bit seen;

        vecs[0] = '{a: 8'd13,  b: 8'd11,   stall: 0, exp: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255,  stall: 0, exp: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200,  stall: 0, exp: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,    stall: 0, exp: 16'd0};
        vecs[4] = '{a: 8'd6,   b: 8'd7,    stall: 5, exp: 16'd42};
        vecs[5] = '{a: 8'd50,  b: 8'd1,    stall: 0, exp: 16'd50};
        vecs[6] = '{a: 8'd50,  b: 8'h80,   stall: 0, exp: 16'd6400};
        vecs[7] = '{a: 8'd1,   b: 8'd255,  stall: 2, exp: 16'd255};
        vecs[8] = '{a: 8'd128, b: 8'd2,    stall: 0, exp: 16'd256};

        rst = 1'b1;
        in_valid8 = 1'b0;  a8 = '0;  b8 = '0;  out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values.
        check("reset in_ready8",  32'(in_ready8),  32'(1));
        check("reset out_valid8", 32'(out_valid8), 32'(0));
        check("reset busy8",      32'(busy8),      32'(0));
        check("reset product8",   32'(product8),   32'(0));
        check("reset in_ready16", 32'(in_ready16), 32'(1));
        check("reset product16",  product16,       32'(0));

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp);
        end

        // Operands offered during a stalled DONE are ignored until IDLE.
        @(negedge clk);
        a8 = 8'd6; b8 = 8'd7; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        wait_out8("hold", edges);
        a8 = 8'd3; b8 = 8'd3; in_valid8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold product", 32'(product8), 32'(42));
            check("hold in_ready", 32'(in_ready8), 32'(0));
            check("hold out_valid", 32'(out_valid8), 32'(1));
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        check("hold back to idle", 32'(in_ready8), 32'(1));
        check("hold product kept in idle", 32'(product8), 32'(42));
        @(negedge clk);
        in_valid8 = 1'b0;
        check("hold second accepted", 32'(busy8), 32'(1));
        wait_out8("hold second", edges);
        check("hold second latency", 32'(edges), 32'(exp_runs8(8'd3)));
        check("hold second product", 32'(product8), 32'(9));
        @(negedge clk);
        check("hold second retired", 32'(out_valid8), 32'(0));

        // Reset at the 4th RUN edge discards the operation.
        a8 = 8'd100; b8 = 8'd100; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready",  32'(in_ready8),  32'(1));
        check("abort out_valid", 32'(out_valid8), 32'(0));
        check("abort busy",      32'(busy8),      32'(0));
        check("abort product",   32'(product8),   32'(0));
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid8 || busy8) seen = 1'b1;
        end
        check("abort no result", 32'(seen), 32'(0));
        run_vec("after abort", 8'd2, 8'd3, 0, 16'd6);

        // Random back-to-back traffic on both widths.
        @(posedge clk);
        #1;
        rand_on = 1'b1;
        fork
            begin : drv8
                for (int n = 0; n < NUM_RAND; n++) begin
                    bit taken;
                    a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'b1;
                    taken = 1'b0;
                    for (int g = 0; g < 200 && !taken; g++) begin
                        @(negedge clk);
                        taken = in_ready8;
                    end
                    check("rand8 accept", 32'(taken), 32'(1));
                    if (taken) exp_q8.push_back(16'(a8) * 16'(b8));
                    @(posedge clk);
                    #1;
                    in_valid8 = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drv8_done = 1'b1;
            end
            begin : drv16
                for (int n = 0; n < NUM_RAND; n++) begin
                    bit taken;
                    a16 = 16'($urandom); b16 = 16'($urandom); in_valid16 = 1'b1;
                    taken = 1'b0;
                    for (int g = 0; g < 300 && !taken; g++) begin
                        @(negedge clk);
                        taken = in_ready16;
                    end
                    check("rand16 accept", 32'(taken), 32'(1));
                    if (taken) exp_q16.push_back(32'(a16) * 32'(b16));
                    @(posedge clk);
                    #1;
                    in_valid16 = 1'b0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drv16_done = 1'b1;
            end
            begin : rdy8
                for (int c = 0; c < 4000 && !(drv8_done && exp_q8.size() == 0); c++) begin
                    @(posedge clk);
                    #1;
                    out_ready8 = ($urandom_range(0, 3) != 0);
                end
                out_ready8 = 1'b1;
            end
            begin : rdy16
                for (int c = 0; c < 6000 && !(drv16_done && exp_q16.size() == 0); c++) begin
                    @(posedge clk);
                    #1;
                    out_ready16 = ($urandom_range(0, 3) != 0);
                end
                out_ready16 = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        rand_on = 1'b0;
        check("rand8 queue drained",  32'(exp_q8.size()),  32'(0));
        check("rand16 queue drained", 32'(exp_q16.size()), 32'(0));
        check("rand8 result count",   32'(got8),  32'(NUM_RAND));
        check("rand16 result count",  32'(got16), 32'(NUM_RAND));
        check("rand8 idle at end",    32'(busy8),  32'(0));
        check("rand16 idle at end",   32'(busy16), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
